muskbus_demux: RTL and testbench

MUSKBUS_DEMUX -- requirements
Module: muskbus_demux

---
 rtl/muskbus_demux_if.sv | 53 +++++
 rtl/muskbus_demux.sv | 131 +++++++++++++
 tb/tb_muskbus_demux.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muskbus_demux_if.sv
// MUSKBUS request/response types and the demux-facing bus bundle.
// One upstream initiator side plus N packed downstream target lanes.
package MUSKBUS;
    typedef struct packed {
        logic        bid;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;
endpackage

interface muskbus_demux_if #(
    parameter int N = 2
);
    import MUSKBUS::*;

    req_t           top_req;
    logic           top_reqack;
    resp_t          top_resp;
    logic           top_respack;
    req_t  [N-1:0]  bottom_reqs;
    logic  [N-1:0]  bottom_reqacks;
    resp_t [N-1:0]  bottom_resps;
    logic  [N-1:0]  bottom_respacks;

    modport slave (
        input  top_req,
        input  top_respack,
        input  bottom_reqacks,
        input  bottom_resps,
        output top_reqack,
        output top_resp,
        output bottom_reqs,
        output bottom_respacks
    );

    modport master (
        output top_req,
        output top_respack,
        output bottom_reqacks,
        output bottom_resps,
        input  top_reqack,
        input  top_resp,
        input  bottom_reqs,
        input  bottom_respacks
    );
endinterface

// File: rtl/muskbus_demux.sv
// MUSKBUS 1-to-N address demux; port chosen by addr[SEL_LSB +: clog2(N)].
// Optional MUSKBUS_DEMUX_DECERR_EN answers undecodable addresses with err.
module muskbus_demux #(
    parameter int N       = 2,
    parameter int SEL_LSB = 28
) (
    input  logic            clk,
    input  logic            reset,
    muskbus_demux_if.slave  bus,
    output logic [15:0]     txn_count
);
    import MUSKBUS::*;

    localparam int SW = $clog2(N);

`ifdef MUSKBUS_DEMUX_DECERR_EN
    typedef enum logic [1:0] {IDLE, BUSY, DECERR} state_e;
`else
    typedef enum logic [1:0] {IDLE, BUSY} state_e;
`endif

    state_e          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [SW-1:0]   idx;
    logic            idx_ok;
    logic            bid;
    logic            route_en;
    logic [SW-1:0]   route_sel;
    logic [15:0]     cnt_inc;

    assign bid     = bus.top_req.bid;
    assign idx     = bus.top_req.addr[SEL_LSB +: SW];
    assign idx_ok  = int'(idx) < N;
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bid) begin
                    if (idx_ok) begin
                        state_d = BUSY;
                        sel_d   = idx;
                    end else begin
`ifdef MUSKBUS_DEMUX_DECERR_EN
                        state_d = DECERR;
`else
                        // undecodable addresses fall through to the last port
                        state_d = BUSY;
                        sel_d   = SW'(N - 1);
`endif
                    end
                end
            end
            BUSY: begin
                if (!bid) begin
                    state_d = IDLE;
                    cnt_d   = cnt_inc;
                end
            end
`ifdef MUSKBUS_DEMUX_DECERR_EN
            DECERR: begin
                if (!bid) begin
                    state_d = IDLE;
                    cnt_d   = cnt_inc;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.bottom_reqs     = '0;
        bus.bottom_respacks = '0;
        bus.top_reqack      = 1'b0;
        bus.top_resp        = '0;
        route_en            = 1'b0;
        route_sel           = sel_q;
        if (!reset) begin
            unique case (state_q)
                // route on the next selection so the first bid cycle lands
                IDLE: begin
                    route_en  = (state_d == BUSY);
                    route_sel = sel_d;
                end
                BUSY: begin
                    route_en  = 1'b1;
                    route_sel = sel_q;
                end
`ifdef MUSKBUS_DEMUX_DECERR_EN
                DECERR: begin
                    bus.top_reqack   = bid;
                    bus.top_resp.err = bid;
                end
`endif
                default: route_en = 1'b0;
            endcase
`ifdef MUSKBUS_DEMUX_DECERR_EN
            if (state_q == IDLE && state_d == DECERR) begin
                bus.top_reqack   = 1'b1;
                bus.top_resp.err = 1'b1;
            end
`endif
            if (route_en) begin
                bus.bottom_reqs[route_sel]     = bus.top_req;
                bus.bottom_respacks[route_sel] = bus.top_respack;
                bus.top_reqack                 = bus.bottom_reqacks[route_sel];
                bus.top_resp                   = bus.bottom_resps[route_sel];
            end
        end
    end

    assign txn_count = reset ? 16'h0000 : cnt_q;

endmodule

// File: tb/tb_muskbus_demux.sv
// Bench for muskbus_demux (N=3): directed scenarios plus random traffic,
// checked every cycle against a transaction-level model.
module tb_muskbus_demux;
    import MUSKBUS::*;

    localparam int N       = 3;
    localparam int SEL_LSB = 28;
    localparam int W       = $clog2(N);

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] txn_count;

    muskbus_demux_if #(.N(N)) bus ();

    muskbus_demux #(.N(N), .SEL_LSB(SEL_LSB)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model: one open transaction at most, bound to a port (-1 = decode error)
    bit m_busy = 1'b0;
    int m_port = 0;
    int m_cnt  = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        int idx;
        idx = int'((a >> SEL_LSB) & ((32'd1 << W) - 32'd1));
        if (idx < N) return idx;
`ifdef MUSKBUS_DEMUX_DECERR_EN
        return -1;
`else
        return N - 1;
`endif
    endfunction

    always @(negedge clk) begin
        int             p;
        req_t  [N-1:0]  er;
        logic  [N-1:0]  ea;
        logic           eack;
        resp_t          ersp;
        logic  [15:0]   ec;
        if (chk_en) begin
            er   = '0;
            ea   = '0;
            eack = 1'b0;
            ersp = '0;
            p    = -2;
            if (!reset) begin
                if (m_busy) p = m_port;
                else if (bus.top_req.bid) p = decode(bus.top_req.addr);
                if (p >= 0) begin
                    er[p] = bus.top_req;
                    ea[p] = bus.top_respack;
                    eack  = bus.bottom_reqacks[p];
                    ersp  = bus.bottom_resps[p];
                end else if (p == -1 && bus.top_req.bid) begin
                    eack     = 1'b1;
                    ersp.err = 1'b1;
                end
            end
            ec = reset ? 16'h0 : m_cnt[15:0];
            chk("m_reqs", 256'(bus.bottom_reqs), 256'(er));
            chk("m_respacks", 256'(bus.bottom_respacks), 256'(ea));
            chk("m_reqack", 256'(bus.top_reqack), 256'(eack));
            chk("m_resp", 256'(bus.top_resp), 256'(ersp));
            chk("m_count", 256'(txn_count), 256'(ec));
            if (reset) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end else if (m_busy) begin
                if (!bus.top_req.bid) begin
                    m_busy = 1'b0;
                    if (m_cnt < 65535) m_cnt++;
                end
            end else if (bus.top_req.bid) begin
                m_busy = 1'b1;
                m_port = p;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic b, input logic [31:0] a);
        bus.top_req.bid   = b;
        bus.top_req.addr  = a;
        bus.top_req.we    = 1'($urandom);
        bus.top_req.wdata = $urandom;
        bus.top_req.be    = 4'($urandom);
    endtask

    task automatic rand_targets();
        bus.top_respack    = 1'($urandom);
        bus.bottom_reqacks = N'($urandom);
        for (int i = 0; i < N; i++) begin
            bus.bottom_resps[i].err   = 1'($urandom);
            bus.bottom_resps[i].rdata = $urandom;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 4) != 0) begin
            a[31:28] = 4'($urandom_range(0, 3));
        end
        return a;
    endfunction

    initial begin
        reset = 1'b1;
        set_req(1'b0, 32'h0);
        bus.top_respack    = 1'b0;
        bus.bottom_reqacks = '0;
        bus.bottom_resps   = '0;
        step();
        chk_en = 1'b1;

        // reset with bid asserted: everything quiet
        set_req(1'b1, 32'h1000_0000);
        bus.bottom_reqacks = '1;
        bus.top_respack    = 1'b1;
        rand_targets();
        bus.bottom_reqacks = '1;
        step();
        #2;
        chk("rst_reqs", 256'(bus.bottom_reqs), 256'(0));
        chk("rst_ack", 256'(bus.top_reqack), 256'(0));
        chk("rst_resp", 256'(bus.top_resp), 256'(0));
        chk("rst_cnt", 256'(txn_count), 256'(0));

        // port1 txn, only port1's ack counts
        step();
        reset = 1'b0;
        set_req(1'b1, 32'h1000_0000);
        bus.top_respack    = 1'b0;
        bus.bottom_reqacks = 3'b101;
        bus.bottom_resps[0] = {1'b1, 32'hDEAD_0000};
        bus.bottom_resps[1] = {1'b0, 32'hCAFE_0001};
        bus.bottom_resps[2] = {1'b1, 32'hDEAD_0002};
        #2;
        chk("p1_bid", 256'(bus.bottom_reqs[1].bid), 256'(1));
        chk("p1_p0zero", 256'(bus.bottom_reqs[0]), 256'(0));
        chk("p1_p2zero", 256'(bus.bottom_reqs[2]), 256'(0));
        chk("p1_noack", 256'(bus.top_reqack), 256'(0));
        step();
        step();
        step();
        bus.bottom_reqacks = 3'b010;
        #2;
        chk("p1_ack", 256'(bus.top_reqack), 256'(1));
        chk("p1_resp", 256'(bus.top_resp), 256'({1'b0, 32'hCAFE_0001}));
        step();
        set_req(1'b0, 32'h1000_0000);
        bus.bottom_reqacks = '0;
        step();
        #2;
        chk("p1_cnt", 256'(txn_count), 256'(1));
        chk("p1_idle", 256'(bus.bottom_reqs), 256'(0));

        // address change mid-txn must not re-route
        step();
        set_req(1'b1, 32'h0000_0040);
        bus.top_respack = 1'b1;
        step();
        set_req(1'b1, 32'h1000_0000);
        #2;
        chk("hold_addr", 256'(bus.bottom_reqs[0].addr), 256'(32'h1000_0000));
        chk("hold_p1", 256'(bus.bottom_reqs[1]), 256'(0));
        chk("hold_racks", 256'(bus.bottom_respacks), 256'(3'b001));
        step();
        set_req(1'b0, 32'h0);
        step();
        #2;
        chk("hold_cnt", 256'(txn_count), 256'(2));

        // idx 3 is out of range for N=3
        step();
        set_req(1'b1, 32'h3000_0000);
        bus.bottom_reqacks  = 3'b111;
        bus.bottom_resps[2] = {1'b0, 32'h2222_0002};
        #2;
`ifdef MUSKBUS_DEMUX_DECERR_EN
        chk("de_ack", 256'(bus.top_reqack), 256'(1));
        chk("de_resp", 256'(bus.top_resp), 256'({1'b1, 32'h0}));
        chk("de_reqs", 256'(bus.bottom_reqs), 256'(0));
        chk("de_racks", 256'(bus.bottom_respacks), 256'(0));
`else
        chk("inv_bid", 256'(bus.bottom_reqs[2].bid), 256'(1));
        chk("inv_resp", 256'(bus.top_resp), 256'({1'b0, 32'h2222_0002}));
        chk("inv_racks", 256'(bus.bottom_respacks), 256'(3'b100));
`endif
        step();
        set_req(1'b0, 32'h0);
        step();
        #2;
        chk("inv_cnt", 256'(txn_count), 256'(3));

        // reset mid-txn with bid held, then fresh decode
        step();
        set_req(1'b1, 32'h1000_0000);
        step();
        reset = 1'b1;
        #2;
        chk("mr_reqs", 256'(bus.bottom_reqs), 256'(0));
        chk("mr_ack", 256'(bus.top_reqack), 256'(0));
        step();
        reset = 1'b0;
        set_req(1'b1, 32'h2000_0000);
        #2;
        chk("mr_redec", 256'(bus.bottom_reqs[2].bid), 256'(1));
        chk("mr_p1", 256'(bus.bottom_reqs[1]), 256'(0));
        chk("mr_cnt", 256'(txn_count), 256'(0));
        step();
        set_req(1'b0, 32'h0);
        step();

        // saturation from FFFE
        force dut.cnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        #1;
        release dut.cnt_q;
        for (int t = 0; t < 3; t++) begin
            step();
            set_req(1'b1, 32'h0000_0100);
            step();
            set_req(1'b0, 32'h0);
        end
        step();
        #2;
        chk("sat_cnt", 256'(txn_count), 256'(16'hFFFF));

        // random traffic with occasional resets
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int t = 0; t < 300; t++) begin
            int gap;
            int len;
            logic [31:0] a;
            gap = $urandom_range(0, 2);
            len = $urandom_range(1, 4);
            for (int g = 0; g < gap; g++) begin
                step();
                rand_targets();
                set_req(1'b0, rand_addr());
                reset = ($urandom_range(0, 59) == 0);
            end
            a = rand_addr();
            for (int c = 0; c < len; c++) begin
                step();
                rand_targets();
                if (c > 0 && $urandom_range(0, 9) < 3) a = rand_addr();
                set_req(1'b1, a);
                reset = ($urandom_range(0, 59) == 0);
            end
        end
        step();
        reset = 1'b0;
        set_req(1'b0, 32'h0);
        step();
        step();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
